alu_issue: RTL

//  EX-entry stage directly upstream of the ALU: one-entry pipeline register between decode
//  and the ALU. Captures a decoded op and selects operands (register, immediate, forwarded

---
 rtl/musa_defs_pkg.sv | 32 +++
 rtl/alu_fwd_mux.sv | 44 ++++
 rtl/alu_issue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/musa_defs_pkg.sv
// musa_defs: shared definitions for the EX-entry (issue) stage and its helpers.
//
// Contents:
//    W          datapath width of ALU operands and results
//    RA         register address width
//    REG_ZERO   address of the hardwired-zero register
//    alu_func_e ALU function codes, FUNC_ADD .. FUNC_NOT
//    isSourceReg  true when an address names a real (non-zero) register
package musa_defs;

    localparam int W  = 32;
    localparam int RA = 5;

    localparam logic [RA-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        FUNC_ADD = 3'b000,
        FUNC_SUB = 3'b001,
        FUNC_MUL = 3'b010,
        FUNC_DIV = 3'b011,
        FUNC_AND = 3'b100,
        FUNC_OR  = 3'b101,
        FUNC_NOT = 3'b110
    } alu_func_e;

    // Register 0 always reads as zero, so it never takes part in forwarding
    // or hazard detection.
    function automatic logic isSourceReg(input logic [RA-1:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// alu_fwd_mux: per-operand source select for the issue stage.
//
// Picks the value for one source register: zero for r0, otherwise the MEM
// result if MEM is about to write that register, otherwise the WB result if
// WB is writing it, otherwise the register-file value. MEM is the younger
// producer, so it wins over WB.
//
// Ports:
//    addr_i        source register address
//    regData_i     register-file value for addr_i
//    memWrEn_i     MEM stage writes memRdAddr_i
//    memRdAddr_i   MEM destination register
//    memResult_i   MEM result
//    wbWrEn_i      WB stage writes wbRdAddr_i
//    wbRdAddr_i    WB destination register
//    wbResult_i    WB result
//    data_o        selected operand value
module alu_fwd_mux
    import musa_defs::*;
(
    input  logic [RA-1:0] addr_i,
    input  logic [W-1:0]  regData_i,
    input  logic          memWrEn_i,
    input  logic [RA-1:0] memRdAddr_i,
    input  logic [W-1:0]  memResult_i,
    input  logic          wbWrEn_i,
    input  logic [RA-1:0] wbRdAddr_i,
    input  logic [W-1:0]  wbResult_i,
    output logic [W-1:0]  data_o
);

    // Priority chain: r0 first, then the younger MEM producer, then WB.
    always_comb begin
        data_o = regData_i;
        if (!isSourceReg(addr_i)) begin
            data_o = '0;
        end else if (memWrEn_i && (memRdAddr_i == addr_i)) begin
            data_o = memResult_i;
        end else if (wbWrEn_i && (wbRdAddr_i == addr_i)) begin
            data_o = wbResult_i;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: one-entry pipeline register between decode and the ALU.
//
// Captures a decoded op, resolves its operands (register, immediate,
// forwarded MEM/WB result), and presents op1/op2/func to the ALU under a
// valid/ready handshake. Divide-by-zero and writes to r0 are flagged here so
// the ALU never has to look at them.
//
// Configuration macro: ALU_ISSUE_FWD_EN
//    defined   - operands forwarded from MEM/WB at capture, and a held op
//                snoops WB writes to its source registers.
//    undefined - no forwarding; an offered op whose non-zero source is being
//                written by MEM or WB is stalled (id_ready=0) until clear.
//
// Ports:
//    clk, reset           clock and synchronous active-high reset
//    id_valid/id_ready    decode handshake
//    id_func              ALU function code
//    id_rs_addr/data      source 1 address and register-file value
//    id_rt_addr/data      source 2 address and register-file value
//    id_imm, id_use_imm   sign-extended immediate, replaces rt when set
//    id_rd_addr, id_wr_en destination and its write enable
//    mem_wr_en/rd_addr/result  MEM stage write (forwarding source)
//    wb_wr_en/rd_addr/result   WB stage write (forwarding/snoop source)
//    flush                discard the held op, refuse new ops this cycle
//    ex_valid/ex_ready    ALU handshake
//    ex_op1, ex_op2       operands
//    ex_func              function code
//    ex_rd_addr, ex_wr_en destination; write enable is 0 for r0
//    ex_div_zero          held op is a divide with a zero divisor
module alu_issue
    import musa_defs::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [2:0]    id_func,
    input  logic [RA-1:0] id_rs_addr,
    input  logic [RA-1:0] id_rt_addr,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [W-1:0]  id_imm,
    input  logic          id_use_imm,
    input  logic [RA-1:0] id_rd_addr,
    input  logic          id_wr_en,
    input  logic          mem_wr_en,
    input  logic [RA-1:0] mem_rd_addr,
    input  logic [W-1:0]  mem_result,
    input  logic          wb_wr_en,
    input  logic [RA-1:0] wb_rd_addr,
    input  logic [W-1:0]  wb_result,
    input  logic          flush,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [W-1:0]  ex_op1,
    output logic [W-1:0]  ex_op2,
    output logic [2:0]    ex_func,
    output logic [RA-1:0] ex_rd_addr,
    output logic          ex_wr_en,
    output logic          ex_div_zero
);

    logic          exValid_q,  exValid_d;
    logic [W-1:0]  exOp1_q,    exOp1_d;
    logic [W-1:0]  exOp2_q,    exOp2_d;
    logic [2:0]    exFunc_q,   exFunc_d;
    logic [RA-1:0] exRd_q,     exRd_d;
    logic          exWrEn_q,   exWrEn_d;
    logic          divZero_q,  divZero_d;
    logic [RA-1:0] rsAddr_q,   rsAddr_d;
    logic [RA-1:0] rtAddr_q,   rtAddr_d;
    logic          useImm_q,   useImm_d;

    logic          fwdMemEn;
    logic          fwdWbEn;
    logic          hazard;
    logic          accept;
    logic [W-1:0]  rsSel;
    logic [W-1:0]  rtSel;
    logic [W-1:0]  op2Sel;
    logic          snoopOp1;
    logic          snoopOp2;

`ifdef ALU_ISSUE_FWD_EN
    localparam logic SNOOP_EN = 1'b1;

    assign fwdMemEn = mem_wr_en;
    assign fwdWbEn  = wb_wr_en;
    assign hazard   = 1'b0;
`else
    localparam logic SNOOP_EN = 1'b0;

    // A pending MEM or WB write to a real source register makes the
    // register-file value stale; the op waits until the write has landed.
    function automatic logic pendingWrite(input logic [RA-1:0] addr);
        return isSourceReg(addr) &&
               ((mem_wr_en && (mem_rd_addr == addr)) ||
                (wb_wr_en  && (wb_rd_addr  == addr)));
    endfunction

    assign fwdMemEn = 1'b0;
    assign fwdWbEn  = 1'b0;
    assign hazard   = id_valid &&
                      (pendingWrite(id_rs_addr) ||
                       (!id_use_imm && pendingWrite(id_rt_addr)));
`endif

    alu_fwd_mux uRsMux (
        .addr_i      (id_rs_addr),
        .regData_i   (id_rs_data),
        .memWrEn_i   (fwdMemEn),
        .memRdAddr_i (mem_rd_addr),
        .memResult_i (mem_result),
        .wbWrEn_i    (fwdWbEn),
        .wbRdAddr_i  (wb_rd_addr),
        .wbResult_i  (wb_result),
        .data_o      (rsSel)
    );

    alu_fwd_mux uRtMux (
        .addr_i      (id_rt_addr),
        .regData_i   (id_rt_data),
        .memWrEn_i   (fwdMemEn),
        .memRdAddr_i (mem_rd_addr),
        .memResult_i (mem_result),
        .wbWrEn_i    (fwdWbEn),
        .wbRdAddr_i  (wb_rd_addr),
        .wbResult_i  (wb_result),
        .data_o      (rtSel)
    );

    // The immediate bypasses forwarding entirely.
    assign op2Sel = id_use_imm ? id_imm : rtSel;

    // The slot frees up when empty or when the ALU takes the op this cycle.
    // Flush and reset both refuse new work.
    assign id_ready = !reset && !flush && (!exValid_q || ex_ready) && !hazard;
    assign accept   = id_valid && id_ready;

    // A held op keeps watching WB so it does not leave with a stale operand.
    assign snoopOp1 = SNOOP_EN && wb_wr_en && isSourceReg(rsAddr_q) &&
                      (wb_rd_addr == rsAddr_q);
    assign snoopOp2 = SNOOP_EN && wb_wr_en && !useImm_q && isSourceReg(rtAddr_q) &&
                      (wb_rd_addr == rtAddr_q);

    // Next-state: flush drops the op, a new op replaces the old one, a
    // stalled op holds (with snoop), and a consumed op with nothing behind it
    // empties the slot. Divide-by-zero follows whatever op2 ends up being.
    always_comb begin
        exValid_d = exValid_q;
        exOp1_d   = exOp1_q;
        exOp2_d   = exOp2_q;
        exFunc_d  = exFunc_q;
        exRd_d    = exRd_q;
        exWrEn_d  = exWrEn_q;
        rsAddr_d  = rsAddr_q;
        rtAddr_d  = rtAddr_q;
        useImm_d  = useImm_q;

        if (flush) begin
            exValid_d = 1'b0;
        end else if (accept) begin
            exValid_d = 1'b1;
            exOp1_d   = rsSel;
            exOp2_d   = op2Sel;
            exFunc_d  = id_func;
            exRd_d    = id_rd_addr;
            exWrEn_d  = id_wr_en && isSourceReg(id_rd_addr);
            rsAddr_d  = id_rs_addr;
            rtAddr_d  = id_rt_addr;
            useImm_d  = id_use_imm;
        end else if (exValid_q && !ex_ready) begin
            if (snoopOp1) begin
                exOp1_d = wb_result;
            end
            if (snoopOp2) begin
                exOp2_d = wb_result;
            end
        end else if (ex_ready) begin
            exValid_d = 1'b0;
        end

        divZero_d = (exFunc_d == FUNC_DIV) && (exOp2_d == '0);
    end

    // Stage registers; reset clears everything so all outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            exValid_q <= 1'b0;
            exOp1_q   <= '0;
            exOp2_q   <= '0;
            exFunc_q  <= '0;
            exRd_q    <= '0;
            exWrEn_q  <= 1'b0;
            divZero_q <= 1'b0;
            rsAddr_q  <= '0;
            rtAddr_q  <= '0;
            useImm_q  <= 1'b0;
        end else begin
            exValid_q <= exValid_d;
            exOp1_q   <= exOp1_d;
            exOp2_q   <= exOp2_d;
            exFunc_q  <= exFunc_d;
            exRd_q    <= exRd_d;
            exWrEn_q  <= exWrEn_d;
            divZero_q <= divZero_d;
            rsAddr_q  <= rsAddr_d;
            rtAddr_q  <= rtAddr_d;
            useImm_q  <= useImm_d;
        end
    end

    assign ex_valid    = exValid_q;
    assign ex_op1      = exOp1_q;
    assign ex_op2      = exOp2_q;
    assign ex_func     = exFunc_q;
    assign ex_rd_addr  = exRd_q;
    assign ex_wr_en    = exValid_q && exWrEn_q;
    assign ex_div_zero = exValid_q && divZero_q;

endmodule
